jump_sequencer: RTL and testbench

//  Frame-rate controller that sequences Mario's vertical motion. It decodes the jump key

---
 rtl/mario_motion_pkg.sv | 37 +++
 rtl/jump_sequencer_if.sv | 21 ++
 rtl/key_edge_detect.sv | 34 +++
 rtl/jump_sequencer.sv | 126 ++++++++++++
 tb/tb_jump_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mario_motion_pkg.sv
// rtl/mario_motion_pkg.sv - shared types, scancodes and jump profile for vertical motion
package mario_motion_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISE     = 2'd1,
        APEX     = 2'd2,
        FALL     = 2'd3
    } jump_state_t;

    // USB HID usage IDs for the keys the game cares about
    localparam logic [7:0] HID_KEY_NONE  = 8'h00;
    localparam logic [7:0] HID_KEY_A     = 8'h04;
    localparam logic [7:0] HID_KEY_D     = 8'h07;
    localparam logic [7:0] HID_KEY_S     = 8'h16;
    localparam logic [7:0] HID_KEY_W     = 8'h1A;
    localparam logic [7:0] HID_KEY_SPACE = 8'h2C;

    localparam int PROFILE_LEN = 20;

    // Upward speed per rise frame; decays in pairs so the arc looks smooth at 60 Hz
    function automatic logic [4:0] jump_profile(input logic [4:0] idx);
        logic [4:0] v;
        case (idx)
            5'd0,  5'd1:                v = 5'd14;
            5'd2,  5'd3:                v = 5'd12;
            5'd4,  5'd5:                v = 5'd10;
            5'd6,  5'd7:                v = 5'd8;
            5'd8,  5'd9:                v = 5'd6;
            5'd10, 5'd11, 5'd12, 5'd13: v = 5'd4;
            5'd14, 5'd15, 5'd16, 5'd17: v = 5'd2;
            default:                    v = 5'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/jump_sequencer_if.sv
// rtl/jump_sequencer_if.sv - keyboard/collision inputs and velocity outputs of the jump sequencer
interface jump_sequencer_if;
    logic [31:0] keycode;
    logic        hit_ground;
    logic        hit_ceiling;
    logic [9:0]  y_motion;
    logic        airborne;
    logic        jump_start;

    // master: the side supplying keys and collisions and consuming velocity
    modport master (
        output keycode, hit_ground, hit_ceiling,
        input  y_motion, airborne, jump_start
    );

    // slave: the jump sequencer itself
    modport slave (
        input  keycode, hit_ground, hit_ceiling,
        output y_motion, airborne, jump_start
    );
endinterface

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - matches one scancode across four HID slots and flags new presses
module key_edge_detect (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic [7:0]  key,
    output logic        key_down,
    output logic        press
);

    logic key_prev;

    // key is down if any of the four report slots carries it
    always_comb begin
        key_down = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[8*i +: 8] == key) begin
                key_down = 1'b1;
            end
        end
    end

    // previous-frame key level; starts high so a key held through reset must be released first
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            key_prev <= 1'b1;
        end else begin
            key_prev <= key_down;
        end
    end

    assign press = key_down & ~key_prev;

endmodule

// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - rise/apex/fall sequencer producing Mario's per-frame y velocity
module jump_sequencer
    import mario_motion_pkg::*;
#(
    parameter logic [7:0] JUMP_KEY    = HID_KEY_W,
    parameter int         RISE_FRAMES = 20,
    parameter int         MIN_RISE    = 6,
    parameter int         APEX_FRAMES = 2,
    parameter int         GRAVITY     = 1,
    parameter int         MAX_FALL    = 8
) (
    input  logic           frame_clk,
    input  logic           Reset,
    jump_sequencer_if.slave bus
);

    localparam logic [4:0] RISE_LAST = 5'(RISE_FRAMES - 1);
    localparam logic [4:0] MIN_LAST  = 5'(MIN_RISE - 1);
    localparam logic [1:0] APEX_LAST = 2'(APEX_FRAMES - 1);
    localparam logic [4:0] GRAV5     = 5'(GRAVITY);
    localparam logic [4:0] MAXF5     = 5'(MAX_FALL);

    jump_state_t state_q, state_d;
    logic [4:0]  rise_cnt_q, rise_cnt_d;
    logic [1:0]  apex_cnt_q, apex_cnt_d;
    logic [3:0]  fall_v_q, fall_v_d;
    logic [4:0]  fall_sum;
    logic [3:0]  fall_next;
    logic        key_down;
    logic        press;

    key_edge_detect u_key (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (bus.keycode),
        .key       (JUMP_KEY),
        .key_down  (key_down),
        .press     (press)
    );

    // gravity step, widened by one bit so the clamp sees the true sum
    always_comb begin
        fall_sum  = {1'b0, fall_v_q} + GRAV5;
        fall_next = (fall_sum > MAXF5) ? MAXF5[3:0] : fall_sum[3:0];
    end

    // state and counter registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= GROUNDED;
            rise_cnt_q <= 5'd0;
            apex_cnt_q <= 2'd0;
            fall_v_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            rise_cnt_q <= rise_cnt_d;
            apex_cnt_q <= apex_cnt_d;
            fall_v_q   <= fall_v_d;
        end
    end

    // next-state and counter updates; each entry into a phase restarts that phase's counter
    always_comb begin
        state_d    = state_q;
        rise_cnt_d = rise_cnt_q;
        apex_cnt_d = apex_cnt_q;
        fall_v_d   = fall_v_q;
        case (state_q)
            GROUNDED: begin
                if (press) begin
                    state_d    = RISE;
                    rise_cnt_d = 5'd0;
                end else if (!bus.hit_ground) begin
                    state_d  = FALL;
                    fall_v_d = 4'd0;
                end
            end
            RISE: begin
                // ground contact is ignored here: the takeoff frame still touches the floor
                rise_cnt_d = rise_cnt_q + 5'd1;
                if (bus.hit_ceiling) begin
                    state_d  = FALL;
                    fall_v_d = 4'd0;
                end else if (rise_cnt_q == RISE_LAST) begin
                    state_d    = APEX;
                    apex_cnt_d = 2'd0;
                end else if (!key_down && (rise_cnt_q >= MIN_LAST)) begin
                    state_d    = APEX;
                    apex_cnt_d = 2'd0;
                end
            end
            APEX: begin
                apex_cnt_d = apex_cnt_q + 2'd1;
                if (bus.hit_ceiling || (apex_cnt_q == APEX_LAST)) begin
                    state_d  = FALL;
                    fall_v_d = 4'd0;
                end
            end
            FALL: begin
                // landing beats everything; a press here is deliberately dropped (no double jump)
                if (bus.hit_ground) begin
                    state_d  = GROUNDED;
                    fall_v_d = 4'd0;
                end else begin
                    fall_v_d = fall_next;
                end
            end
            default: begin
                state_d = GROUNDED;
            end
        endcase
    end

    // Moore outputs decoded from registered state and counters
    always_comb begin
        bus.y_motion   = 10'd0;
        bus.airborne   = (state_q != GROUNDED);
        bus.jump_start = (state_q == RISE) && (rise_cnt_q == 5'd0);
        case (state_q)
            RISE:    bus.y_motion = 10'd0 - {5'd0, jump_profile(rise_cnt_q)};
            FALL:    bus.y_motion = {6'd0, fall_v_q};
            default: bus.y_motion = 10'd0;
        endcase
    end

endmodule

// File: tb/tb_jump_sequencer.sv
// tb/tb_jump_sequencer.sv - directed and randomized checks of jump_sequencer against a phase model
module tb_jump_sequencer;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    jump_sequencer_if bus ();

    jump_sequencer dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    localparam int P_GND  = 0;
    localparam int P_RISE = 1;
    localparam int P_APEX = 2;
    localparam int P_FALL = 3;

    int checks = 0;
    int errors = 0;
    int prof [20] = '{14, 14, 12, 12, 10, 10, 8, 8, 6, 6, 4, 4, 4, 4, 2, 2, 2, 2, 0, 0};

    // model: current phase and how many frames have already been spent in it
    int   m_phase;
    int   m_t;
    logic m_prev;
    int   js_count;
    logic key_on;

    task automatic model_reset();
        m_phase = P_GND;
        m_t     = 0;
        m_prev  = 1'b1;
    endtask

    task automatic model_clock(input logic [31:0] kc, input logic hg, input logic hc);
        logic kd;
        logic pr;
        kd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kc[8*i +: 8] == 8'h1A) kd = 1'b1;
        end
        pr = kd && !m_prev;
        case (m_phase)
            P_GND: begin
                if (pr) begin m_phase = P_RISE; m_t = 0; end
                else if (!hg) begin m_phase = P_FALL; m_t = 0; end
            end
            P_RISE: begin
                if (hc) begin m_phase = P_FALL; m_t = 0; end
                else if (m_t == 19 || (!kd && m_t >= 5)) begin m_phase = P_APEX; m_t = 0; end
                else m_t++;
            end
            P_APEX: begin
                if (hc || m_t == 1) begin m_phase = P_FALL; m_t = 0; end
                else m_t++;
            end
            default: begin
                if (hg) begin m_phase = P_GND; m_t = 0; end
                else m_t++;
            end
        endcase
        m_prev = kd;
    endtask

    function automatic logic [9:0] exp_y();
        int v;
        v = 0;
        if (m_phase == P_RISE) v = -((m_t < 20) ? prof[m_t] : 0);
        else if (m_phase == P_FALL) v = (m_t > 8) ? 8 : m_t;
        return 10'(v);
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expected);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".y"},   bus.y_motion, exp_y());
        chk({tag, ".air"}, {9'd0, bus.airborne}, (m_phase != P_GND) ? 10'd1 : 10'd0);
        chk({tag, ".js"},  {9'd0, bus.jump_start},
            (m_phase == P_RISE && m_t == 0) ? 10'd1 : 10'd0);
        if (bus.jump_start === 1'b1) js_count++;
    endtask

    task automatic step(input string tag, input logic [31:0] kc, input logic hg, input logic hc);
        bus.keycode     = kc;
        bus.hit_ground  = hg;
        bus.hit_ceiling = hc;
        @(posedge frame_clk);
        model_clock(kc, hg, hc);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [7:0] other_key();
        logic [7:0] k;
        case ($urandom_range(0, 4))
            0:       k = 8'h00;
            1:       k = 8'h04;
            2:       k = 8'h07;
            3:       k = 8'h16;
            default: k = 8'h2C;
        endcase
        return k;
    endfunction

    initial begin
        logic [31:0] kc;
        logic        hg;
        logic        hc;

        js_count = 0;
        key_on   = 1'b0;
        model_reset();

        // 1: key held through reset must not jump until released and pressed again
        bus.keycode     = 32'h0000001A;
        bus.hit_ground  = 1'b1;
        bus.hit_ceiling = 1'b0;
        repeat (2) @(posedge frame_clk);
        #1;
        chk("rst_y", bus.y_motion, 10'd0);
        chk("rst_air", {9'd0, bus.airborne}, 10'd0);
        chk("rst_js", {9'd0, bus.jump_start}, 10'd0);
        Reset = 1'b0;
        repeat (3) step("t1_held", 32'h0000001A, 1'b1, 1'b0);
        chk("t1_no_jump", {9'd0, bus.airborne}, 10'd0);
        step("t1_release", 32'h00000000, 1'b1, 1'b0);
        step("t1_press", 32'h001A0000, 1'b1, 1'b0);
        chk("t1_js_pulse", {9'd0, bus.jump_start}, 10'd1);
        chk("t1_first_y", bus.y_motion, 10'h3F2);

        // 2: full-height jump held in slot 2, apex hang, saturating fall, landing
        js_count = 1;
        repeat (19) step("t2_rise", 32'h001A0000, 1'b1, 1'b0);
        chk("t2_last_rise_y", bus.y_motion, 10'd0);
        repeat (2) step("t2_apex", 32'h001A0000, 1'b0, 1'b0);
        chk("t2_apex_air", {9'd0, bus.airborne}, 10'd1);
        repeat (12) step("t2_fall", 32'h001A0000, 1'b0, 1'b0);
        chk("t2_terminal", bus.y_motion, 10'd8);
        step("t2_land", 32'h001A0000, 1'b1, 1'b0);
        chk("t2_js_once", 10'(js_count), 10'd1);
        step("t2_idle", 32'h00000000, 1'b1, 1'b0);

        // 3: short hop, key released after three frames
        step("t3_press", 32'h0000001A, 1'b1, 1'b0);
        repeat (2) step("t3_hold", 32'h0000001A, 1'b1, 1'b0);
        repeat (3) step("t3_rel", 32'h00000000, 1'b1, 1'b0);
        chk("t3_min_rise_y", bus.y_motion, 10'h3F6);
        step("t3_apex", 32'h00000000, 1'b0, 1'b0);
        chk("t3_apex_y", bus.y_motion, 10'd0);
        repeat (6) step("t3_fall", 32'h00000000, 1'b0, 1'b0);
        step("t3_land", 32'h00000000, 1'b1, 1'b0);

        // 4: ceiling bonk on rise frame 4
        step("t4_press", 32'h1A000000, 1'b1, 1'b0);
        repeat (4) step("t4_rise", 32'h1A000000, 1'b1, 1'b0);
        step("t4_bonk", 32'h1A000000, 1'b0, 1'b1);
        chk("t4_bonk_y", bus.y_motion, 10'd0);
        chk("t4_bonk_air", {9'd0, bus.airborne}, 10'd1);
        step("t4_fall1", 32'h1A000000, 1'b0, 1'b0);
        chk("t4_fall1_y", bus.y_motion, 10'd1);
        step("t4_fall2", 32'h1A000000, 1'b0, 1'b0);
        chk("t4_fall2_y", bus.y_motion, 10'd2);
        step("t4_land", 32'h00000000, 1'b1, 1'b0);

        // 5: walk off a ledge, press while falling is ignored
        step("t5_drop", 32'h00000000, 1'b0, 1'b0);
        chk("t5_drop_y", bus.y_motion, 10'd0);
        step("t5_fall", 32'h00000000, 1'b0, 1'b0);
        step("t5_press", 32'h00001A00, 1'b0, 1'b0);
        chk("t5_no_double", bus.y_motion, 10'd2);
        step("t5_hold", 32'h00001A00, 1'b0, 1'b0);
        step("t5_land", 32'h00001A00, 1'b1, 1'b0);
        chk("t5_land_y", bus.y_motion, 10'd0);
        chk("t5_land_air", {9'd0, bus.airborne}, 10'd0);
        step("t5_stay", 32'h00001A00, 1'b1, 1'b0);
        step("t5_release", 32'h00000000, 1'b1, 1'b0);

        // 6: asynchronous reset in the middle of a fall
        repeat (6) step("t6_fall", 32'h00000000, 1'b0, 1'b0);
        chk("t6_pre_y", bus.y_motion, 10'd5);
        #2;
        Reset = 1'b1;
        #1;
        chk("t6_async_y", bus.y_motion, 10'd0);
        chk("t6_async_air", {9'd0, bus.airborne}, 10'd0);
        chk("t6_async_js", {9'd0, bus.jump_start}, 10'd0);
        model_reset();
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        step("t6_after", 32'h00000000, 1'b1, 1'b0);

        // randomized play against the phase model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) key_on = ~key_on;
            for (int i = 0; i < 4; i++) kc[8*i +: 8] = other_key();
            if (key_on) kc[8*$urandom_range(0, 3) +: 8] = 8'h1A;
            if (m_phase == P_GND) hg = ($urandom_range(0, 15) != 0);
            else if (m_phase == P_FALL) hg = ($urandom_range(0, 7) == 0);
            else hg = $urandom_range(0, 1) == 1;
            hc = ($urandom_range(0, 15) == 0);
            step("rnd", kc, hg, hc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
